adder_block_sequencer: RTL and testbench

Bit-serial driver for a single one-bit relay adder cell. It takes two WIDTH-bit operands and a carry-in, then presents one bit pair per step to the cell's b/c/carry-in inputs. After a relay settle window it samples the cell's sum and carry outputs and feeds the carry back for the next bit. It reports the WIDTH-bit sum with carry/zero/sign flags and checks that the dual-rail carry outputs are consistent. It sits between the ALU control sequencer and one adder cell.

---
 rtl/adder_block_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_adder_block_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_block_sequencer.sv
// adder_block_sequencer
// Bit-serial driver for one relay adder cell. Operands are presented one bit
// pair at a time. After a settle window the cell's sum and dual-rail carry are
// sampled, and the carry is fed back for the next bit. The final sum, the carry
// and the derived flags are published in a single DONE cycle.

module adder_block_sequencer #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             fault,
  output logic             cell_b,
  output logic             cell_c,
  output logic             cell_carry_in,
  output logic             cell_carry_in_n,
  input  logic             cell_sum,
  input  logic             cell_carry_out,
  input  logic             cell_carry_out_n
);

  // Bit index and settle counter widths. The counter keeps at least one bit,
  // so a zero settle window still has a legal register.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Zero detect on a full result word.
  function automatic logic f_is_zero(input logic [WIDTH-1:0] v);
    f_is_zero = (v == {WIDTH{1'b0}});
  endfunction

  // Dual-rail carry check: the two rails must always disagree.
  function automatic logic f_rail_bad(input logic rail_p, input logic rail_n);
    f_rail_bad = (rail_p == rail_n);
  endfunction

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_wsum;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_zero;
  logic             r_sign;
  logic             r_fault;
  logic             r_cell_b;
  logic             r_cell_c;
  logic             r_cell_ci;
  logic             r_cell_ci_n;

  logic [WIDTH-1:0] w_sum_next;
  logic [IW-1:0]    w_idx_next;
  logic             w_rail_bad;

  // Working sum with the currently sampled bit merged in, next bit index and rail check.
  always_comb begin
    w_sum_next        = r_wsum;
    w_sum_next[r_idx] = cell_sum;
    w_idx_next        = r_idx + IDX_ONE;
    w_rail_bad        = f_rail_bad(cell_carry_out, cell_carry_out_n);
  end

  // Sequencer FSM: operand latch, per-bit settle/sample and result publication.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_ZERO;
      r_idx       <= IDX_ZERO;
      r_b         <= {WIDTH{1'b0}};
      r_c         <= {WIDTH{1'b0}};
      r_wsum      <= {WIDTH{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sum       <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_sign      <= 1'b0;
      r_fault     <= 1'b0;
      r_cell_b    <= 1'b0;
      r_cell_c    <= 1'b0;
      r_cell_ci   <= 1'b0;
      r_cell_ci_n <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (start) begin
            r_b         <= b_in;
            r_c         <= c_in;
            r_wsum      <= {WIDTH{1'b0}};
            r_idx       <= IDX_ZERO;
            r_cell_b    <= b_in[0];
            r_cell_c    <= c_in[0];
            r_cell_ci   <= cin;
            r_cell_ci_n <= ~cin;
            r_cnt       <= CNT_LOAD;
            r_fault     <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_SETTLE;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_SETTLE: begin
          // Cell inputs are held; only the settle counter moves.
          if (r_cnt == CNT_ZERO) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt   <= r_cnt - CNT_ONE;
            r_state <= S_SETTLE;
          end
        end

        S_SAMPLE: begin
          r_wsum <= w_sum_next;
          if (w_rail_bad) begin
            r_fault <= 1'b1;
          end else begin
            r_fault <= r_fault;
          end
          if (r_idx == IDX_LAST) begin
            // Results are published only here, so they stay stable during an operation.
            r_sum   <= w_sum_next;
            r_carry <= cell_carry_out;
            r_zero  <= f_is_zero(w_sum_next);
            r_sign  <= w_sum_next[WIDTH-1];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx       <= w_idx_next;
            r_cell_b    <= r_b[w_idx_next];
            r_cell_c    <= r_c[w_idx_next];
            r_cell_ci   <= cell_carry_out;
            r_cell_ci_n <= ~cell_carry_out;
            r_cnt       <= CNT_LOAD;
            r_state     <= S_SETTLE;
          end
        end

        S_DONE: begin
          // One-cycle done pulse; start seen here is ignored because the block is still busy.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_cell_ci   <= 1'b0;
          r_cell_ci_n <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign sum             = r_sum;
  assign carry           = r_carry;
  assign zero            = r_zero;
  assign sign            = r_sign;
  assign fault           = r_fault;
  assign cell_b          = r_cell_b;
  assign cell_c          = r_cell_c;
  assign cell_carry_in   = r_cell_ci;
  assign cell_carry_in_n = r_cell_ci_n;

endmodule

// File: tb/tb_adder_block_sequencer.sv
// Scoreboard bench for adder_block_sequencer: random and directed operations
// against an arithmetic reference, with a behavioural dual-rail relay cell.

module tb_adder_block_sequencer;

  localparam int W    = 8;
  localparam int LAT0 = W * (2 + 2);
  localparam int LAT1 = W * (0 + 2);

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       zero;
    logic       sign;
    logic       fault;
    int         acc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // DUT 0 (default settle window)
  logic       start = 1'b0, cin = 1'b0;
  logic [7:0] b_in = 8'd0, c_in = 8'd0;
  logic       busy, done, carry, zero, sign, fault;
  logic [7:0] sum;
  logic       cell_b, cell_c, cell_ci, cell_ci_n;
  logic       cell_sum, cell_co, cell_co_n;
  logic       inj_force = 1'b0;

  // DUT 1 (no settle window)
  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [7:0] b_in1 = 8'd0, c_in1 = 8'd0;
  logic       busy1, done1, carry1, zero1, sign1, fault1;
  logic [7:0] sum1;
  logic       cell_b1, cell_c1, cell_ci1, cell_ci_n1;
  logic       cell_sum1, cell_co1, cell_co_n1;

  exp_t sb[$];
  exp_t sb1[$];
  exp_t mon_e, mon_e1;
  logic [7:0] prev_sum = 8'd0;
  logic       prev_carry = 1'b0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  adder_block_sequencer #(.WIDTH(8), .SETTLE_CYCLES(2)) u_dut0 (
    .clock(clock), .reset(reset), .start(start), .b_in(b_in), .c_in(c_in), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .carry(carry), .zero(zero), .sign(sign),
    .fault(fault), .cell_b(cell_b), .cell_c(cell_c), .cell_carry_in(cell_ci),
    .cell_carry_in_n(cell_ci_n), .cell_sum(cell_sum), .cell_carry_out(cell_co),
    .cell_carry_out_n(cell_co_n)
  );

  adder_block_sequencer #(.WIDTH(8), .SETTLE_CYCLES(0)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .b_in(b_in1), .c_in(c_in1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .zero(zero1), .sign(sign1),
    .fault(fault1), .cell_b(cell_b1), .cell_c(cell_c1), .cell_carry_in(cell_ci1),
    .cell_carry_in_n(cell_ci_n1), .cell_sum(cell_sum1), .cell_carry_out(cell_co1),
    .cell_carry_out_n(cell_co_n1)
  );

  // Relay cell models: full adder with dual-rail carry; cell 0 can be forced to a bad rail pair.
  always_comb begin
    cell_sum  = cell_b ^ cell_c ^ cell_ci;
    cell_co   = (cell_b & cell_c) | (cell_b & cell_ci) | (cell_c & cell_ci);
    cell_co_n = ~cell_co;
    if (inj_force) begin
      cell_co   = 1'b1;
      cell_co_n = 1'b1;
    end
    cell_sum1  = cell_b1 ^ cell_c1 ^ cell_ci1;
    cell_co1   = (cell_b1 & cell_c1) | (cell_b1 & cell_ci1) | (cell_c1 & cell_ci1);
    cell_co_n1 = ~cell_co1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain addition; with a forced carry into bit 4 the halves add separately.
  function automatic exp_t model(input logic [7:0] b, input logic [7:0] c, input logic ci,
                                 input bit inj, input int acc);
    exp_t e;
    logic [8:0] t;
    logic [4:0] lo, hi;
    if (!inj) begin
      t = {1'b0, b} + {1'b0, c} + {8'd0, ci};
      e.sum = t[7:0];
      e.carry = t[8];
    end else begin
      lo = {1'b0, b[3:0]} + {1'b0, c[3:0]} + {4'd0, ci};
      hi = {1'b0, b[7:4]} + {1'b0, c[7:4]} + 5'd1;
      e.sum = {hi[3:0], lo[3:0]};
      e.carry = hi[4];
    end
    e.zero = (e.sum == 8'd0);
    e.sign = e.sum[7];
    e.fault = inj;
    e.acc = acc;
    return e;
  endfunction

  // Monitor for DUT 0: rail complement every cycle, result compare on every done.
  always @(negedge clock) begin
    if (!reset) begin
      check("cin_rail", {31'd0, cell_ci_n}, {31'd0, ~cell_ci});
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("sum", {24'd0, sum}, {24'd0, mon_e.sum});
          check("carry", {31'd0, carry}, {31'd0, mon_e.carry});
          check("zero", {31'd0, zero}, {31'd0, mon_e.zero});
          check("sign", {31'd0, sign}, {31'd0, mon_e.sign});
          check("fault", {31'd0, fault}, {31'd0, mon_e.fault});
          check("busy_at_done", {31'd0, busy}, 32'd1);
          check("latency", cyc - mon_e.acc, LAT0);
        end
      end
    end
  end

  // Monitor for DUT 1.
  always @(negedge clock) begin
    if (!reset && done1) begin
      if (sb1.size() == 0) begin
        check("unexpected_done1", 32'd1, 32'd0);
      end else begin
        mon_e1 = sb1.pop_front();
        check("sum1", {24'd0, sum1}, {24'd0, mon_e1.sum});
        check("carry1", {31'd0, carry1}, {31'd0, mon_e1.carry});
        check("zero1", {31'd0, zero1}, {31'd0, mon_e1.zero});
        check("fault1", {31'd0, fault1}, 32'd0);
        check("latency1", cyc - mon_e1.acc, LAT1);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_sum"}, {24'd0, sum}, 32'd0);
    check({tag, "_flags"}, {28'd0, carry, zero, sign, fault}, 32'd0);
    check({tag, "_cell"}, {28'd0, cell_b, cell_c, cell_ci, cell_ci_n}, 32'd1);
  endtask

  // One operation on DUT 0. rst_k>0 asserts reset that many edges after accept.
  task automatic run_op(input logic [7:0] b, input logic [7:0] c, input logic ci,
                        input bit inj, input bit pulse, input int rst_k,
                        input bit from_done, input bit chain);
    int acc, k;
    bit seen, hold_ok, any_done;
    exp_t e;
    if (!from_done) @(negedge clock);
    b_in = b; c_in = c; cin = ci; start = 1'b1;
    if (from_done) @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    acc = cyc;
    e = model(b, c, ci, inj, acc);
    sb.push_back(e);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    seen = 1'b0;
    hold_ok = 1'b1;
    for (int n = 0; n < LAT0 + 8 && !seen; n++) begin
      @(negedge clock);
      k = cyc - acc;
      if (done) begin
        seen = 1'b1;
      end else if (sum !== prev_sum || carry !== prev_carry) begin
        hold_ok = 1'b0;
      end
      if (inj && k == 12) inj_force = 1'b1;
      if (k == 16) inj_force = 1'b0;
      if (pulse && k == 4) begin
        b_in = 8'($urandom); c_in = 8'($urandom); cin = 1'($urandom); start = 1'b1;
      end
      if (pulse && k == 5) start = 1'b0;
      if (rst_k > 0 && k == rst_k) begin
        reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        void'(sb.pop_back());
        repeat (2) @(negedge clock);
        reset = 1'b0;
        prev_sum = 8'd0;
        prev_carry = 1'b0;
        any_done = 1'b0;
        for (int m = 0; m < LAT0 + 4; m++) begin
          @(negedge clock);
          if (done) any_done = 1'b1;
        end
        check("no_done_after_reset", {31'd0, any_done}, 32'd0);
        return;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("results_held", {31'd0, hold_ok}, 32'd1);
    prev_sum = e.sum;
    prev_carry = e.carry;
    if (!chain) begin
      @(negedge clock);
      check("busy_after_done", {30'd0, busy, done}, 32'd0);
      check("fault_held", {31'd0, fault}, {31'd0, e.fault});
      check("sum_held", {24'd0, sum}, {24'd0, e.sum});
    end
  endtask

  // One operation on DUT 1.
  task automatic run1(input logic [7:0] b, input logic [7:0] c, input logic ci);
    bit seen;
    @(negedge clock);
    b_in1 = b; c_in1 = c; cin1 = ci; start1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start1 = 1'b0;
    sb1.push_back(model(b, c, ci, 1'b0, cyc));
    seen = 1'b0;
    for (int n = 0; n < LAT1 + 8 && !seen; n++) begin
      @(negedge clock);
      if (done1) seen = 1'b1;
    end
    check("done1_seen", {31'd0, seen}, 32'd1);
    @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_reset_state("por");
    check("por_rail1", {31'd0, cell_ci_n1}, 32'd1);
    reset = 1'b0;

    run_op(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h3C, 8'h15, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h3C, 8'h15, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    run_op(8'h5A, 8'h66, 1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b0);
    run_op(8'h81, 8'h81, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_op(8'h40, 8'h3F, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'($urandom), 0, 1'b0, 1'b0);
    end

    run1(8'hAA, 8'h55, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run1(8'($urandom), 8'($urandom), 1'($urandom));
    end

    repeat (4) @(negedge clock);
    check("sb_empty", sb.size() + sb1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
